seg7_scan_decoder: RTL and testbench

- Receive side of the two-digit multiplexed 7-segment display bus driven by the timer/counter block.
- Snoops segment lines and digit enables, filters mux transitions and ghosting, and decodes each digit back to BCD.
- Presents a committed two-digit value with valid, change and error indications.
- Used for on-chip self-check and for forwarding the displayed count to other logic.

---
 rtl/seg7_scan_decoder.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: receive side of the two-digit multiplexed 7-segment bus.
// Synchronizes segment/digit lines, waits for a stable dwell, decodes each
// digit back to BCD and commits the ones/tens pair with valid/change/error
// indications. A timeout drops value_valid when the display goes quiet.
module seg7_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_in,
  output logic [3:0] ones_out,
  output logic [3:0] tens_out,
  output logic [6:0] bin_out,
  output logic       value_valid,
  output logic       value_changed,
  output logic       seg_error
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  STAB_MAX  = 8'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_FULL = TW'(TIMEOUT_CYCLES);

  logic [6:0]    seg_s1, seg_s2;
  logic [1:0]    dig_s1, dig_s2;
  logic [8:0]    samp_cur, samp_prev;
  logic [7:0]    stab_cnt;
  logic          acc_done;
  logic          dig_ok;
  logic          accept;
  logic [3:0]    dec_val;
  logic          dec_ok;
  logic          pend_ones, pend_tens;
  logic [3:0]    pend_ones_val, pend_tens_val;
  logic          commit;
  logic [TW-1:0] to_cnt;
  logic          expire;
  logic [6:0]    bin_next;

  // Two-flop synchronizers on the segment and digit-enable lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      dig_s1 <= dig_in;
      dig_s2 <= dig_s1;
    end
  end

  assign samp_cur = {dig_s2, seg_s2};
  assign dig_ok   = (samp_prev[8:7] == 2'b01) || (samp_prev[8:7] == 2'b10);
  // The counter sitting at its cap means samp_prev has been stable long enough.
  assign accept   = (stab_cnt == STAB_MAX) && !acc_done && dig_ok;

  // Stability filter: count consecutive identical samples, one accept per dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_prev <= '0;
      stab_cnt  <= '0;
      acc_done  <= 1'b0;
    end else begin
      samp_prev <= samp_cur;
      if (samp_cur != samp_prev) begin
        stab_cnt <= '0;
        acc_done <= 1'b0;
      end else begin
        if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 8'd1;
        if (accept) acc_done <= 1'b1;
      end
    end
  end

  // Segment pattern to BCD decode of the accepted sample.
  always_comb begin
    dec_val = '0;
    dec_ok  = 1'b1;
    case (samp_prev[6:0])
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  assign commit = pend_ones && pend_tens;
  assign expire = !accept && (to_cnt == TO_LAST);

  // Idle timeout: restarts on every accept, saturates once expired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_FULL) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Pending digit slots. A bad pattern discards the whole partial pair so
  // the next commit always needs both digits freshly accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ones     <= 1'b0;
      pend_tens     <= 1'b0;
      pend_ones_val <= '0;
      pend_tens_val <= '0;
    end else begin
      if (commit || expire) begin
        pend_ones <= 1'b0;
        pend_tens <= 1'b0;
      end
      if (accept) begin
        if (!dec_ok) begin
          pend_ones <= 1'b0;
          pend_tens <= 1'b0;
        end else if (samp_prev[8:7] == 2'b01) begin
          pend_ones     <= 1'b1;
          pend_ones_val <= dec_val;
        end else begin
          pend_tens     <= 1'b1;
          pend_tens_val <= dec_val;
        end
      end
    end
  end

  assign bin_next = ({3'b000, pend_tens_val} * 7'd10) + {3'b000, pend_ones_val};

  // Committed outputs; a commit overrides a timeout expiring in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_out      <= '0;
      tens_out      <= '0;
      bin_out       <= '0;
      value_valid   <= 1'b0;
      value_changed <= 1'b0;
      seg_error     <= 1'b0;
    end else begin
      seg_error     <= accept && !dec_ok;
      value_changed <= 1'b0;
      if (commit) begin
        ones_out      <= pend_ones_val;
        tens_out      <= pend_tens_val;
        bin_out       <= bin_next;
        value_valid   <= 1'b1;
        value_changed <= !value_valid || (pend_ones_val != ones_out) ||
                         (pend_tens_val != tens_out);
      end else if (expire) begin
        value_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed frames from the test plan followed by
// random dwells, checked against a dwell-level behavioural model.
module tb_seg7_scan_decoder;

  localparam int unsigned SETTLE  = 8;
  localparam int unsigned TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = '0;
  logic [1:0] dig_in = '0;
  logic [3:0] ones_out, tens_out;
  logic [6:0] bin_out;
  logic       value_valid, value_changed, seg_error;

  seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_in(dig_in),
    .ones_out(ones_out), .tens_out(tens_out), .bin_out(bin_out),
    .value_valid(value_valid), .value_changed(value_changed),
    .seg_error(seg_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor
  int chg_seen = 0;
  int err_seen = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chg_seen <= 0;
      err_seen <= 0;
    end else begin
      if (value_changed === 1'b1) chg_seen <= chg_seen + 1;
      if (seg_error === 1'b1)     err_seen <= err_seen + 1;
    end
  end

  // Reference model: display digit table and pair/commit rules.
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int m_ones, m_tens, m_valid, m_po, m_pt, m_pov, m_ptv, m_chg, m_err, m_idle;
  logic [8:0] run_val;
  int run_len;

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ones = 0; m_tens = 0; m_valid = 0; m_po = 0; m_pt = 0;
    m_pov = 0; m_ptv = 0; m_chg = 0; m_err = 0; m_idle = 0;
    run_val = '0; run_len = SETTLE + 100;
  endtask

  task automatic model_accept(input logic [1:0] d, input logic [6:0] p);
    int v;
    v = decode(p);
    m_idle = 0;
    if (v < 0) begin
      m_err++;
      m_po = 0; m_pt = 0;
    end else if (d == 2'b01) begin
      m_po = 1; m_pov = v;
    end else begin
      m_pt = 1; m_ptv = v;
    end
    if (m_po != 0 && m_pt != 0) begin
      if (m_valid == 0 || m_pov != m_ones || m_ptv != m_tens) m_chg++;
      m_ones = m_pov; m_tens = m_ptv; m_valid = 1;
      m_po = 0; m_pt = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ones"},  32'(ones_out),    32'(m_ones));
    check({tag, ".tens"},  32'(tens_out),    32'(m_tens));
    check({tag, ".bin"},   32'(bin_out),     32'(m_tens * 10 + m_ones));
    check({tag, ".valid"}, 32'(value_valid), 32'(m_valid));
    check({tag, ".chg"},   32'(chg_seen),    32'(m_chg));
    check({tag, ".err"},   32'(err_seen),    32'(m_err));
  endtask

  // Hold one {dig,seg} value for len cycles; model runs per cycle, checks once settled.
  task automatic dwell(input logic [1:0] d, input logic [6:0] p, input int len, input string tag);
    dig_in = d;
    seg_in = p;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if ({d, p} == run_val) run_len++;
      else begin
        run_val = {d, p};
        run_len = 1;
      end
      m_idle++;
      if (run_len == SETTLE && (d == 2'b01 || d == 2'b10)) model_accept(d, p);
      if (m_idle == TIMEOUT + 10) begin
        m_valid = 0; m_po = 0; m_pt = 0;
      end
    end
    if (run_len >= SETTLE + 7) check_all(tag);
  endtask

  task automatic frame(input int tens, input int ones, input string tag);
    dwell(2'b01, seg_tab[ones], 20, tag);
    dwell(2'b10, seg_tab[tens], 20, tag);
  endtask

  initial begin
    logic [1:0] rd;
    logic [6:0] rp;
    int rl, r;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.ones",  32'(ones_out),    32'd0);
    check("reset.bin",   32'(bin_out),     32'd0);
    check("reset.valid", 32'(value_valid), 32'd0);
    rst_n = 1'b1;

    // First pair 43
    frame(4, 3, "first43");
    check("first43.bin", 32'(bin_out), 32'd43);
    check("first43.chg", 32'(chg_seen), 32'd1);

    // Identical frames: no further change pulses
    for (int i = 0; i < 5; i++) frame(4, 3, "repeat43");
    check("repeat43.chg",   32'(chg_seen),    32'd1);
    check("repeat43.valid", 32'(value_valid), 32'd1);

    // Fast toggling never settles
    for (int i = 0; i < 10; i++) dwell(2'b01, (i % 2 == 0) ? 7'h3F : 7'h06, 4, "toggle");
    dwell(2'b00, 7'h00, 20, "toggle.idle");
    check("toggle.err", 32'(err_seen), 32'd0);
    check("toggle.bin", 32'(bin_out),  32'd43);

    // Bad tens pattern discards the pending pair
    dwell(2'b01, 7'h7F, 20, "bad.ones");
    dwell(2'b10, 7'h01, 20, "bad.tens");
    check("bad.err", 32'(err_seen), 32'd1);
    dwell(2'b10, 7'h6F, 20, "bad.tens9");
    check("bad.nocommit", 32'(bin_out), 32'd43);
    dwell(2'b01, 7'h3F, 20, "bad.ones0");
    check("bad.bin90", 32'(bin_out), 32'd90);
    check("bad.chg",   32'(chg_seen), 32'd2);

    // Timeout drops valid, holds digits; same value recommits as a change
    dwell(2'b00, 7'h00, TIMEOUT + 40, "timeout");
    check("timeout.valid", 32'(value_valid), 32'd0);
    check("timeout.hold",  32'(bin_out),     32'd90);
    frame(9, 0, "after_to");
    check("after_to.chg",   32'(chg_seen),    32'd3);
    check("after_to.valid", 32'(value_valid), 32'd1);

    // Counting 98 -> 99 -> 00
    frame(9, 8, "cnt98");
    check("cnt98.bin", 32'(bin_out), 32'd98);
    frame(9, 9, "cnt99");
    check("cnt99.bin", 32'(bin_out), 32'd99);
    frame(0, 0, "cnt00");
    check("cnt00.bin", 32'(bin_out), 32'd0);
    check("cnt.chg",   32'(chg_seen), 32'd6);

    // Random dwells
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
      if ($urandom_range(0, 99) < 85) rp = seg_tab[$urandom_range(0, 9)];
      else rp = 7'($urandom);
      rl = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(16, 40);
      dwell(rd, rp, rl, "rand");
    end

    // Reset mid-dwell clears everything immediately
    frame(4, 3, "pre_rst");
    dig_in = 2'b01;
    seg_in = 7'h06;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.ones",  32'(ones_out),    32'd0);
    check("midrst.tens",  32'(tens_out),    32'd0);
    check("midrst.bin",   32'(bin_out),     32'd0);
    check("midrst.valid", 32'(value_valid), 32'd0);
    @(negedge clk);
    model_reset();
    dig_in = 2'b00;
    seg_in = 7'h00;
    @(negedge clk);
    rst_n = 1'b1;
    frame(5, 7, "post_rst");
    check("post_rst.bin", 32'(bin_out), 32'd57);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
